// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_pkg
//  Description : Shared definitions for the instruction-fetch stage: the
//                fetch FSM state encoding, default reset PC, default
//                instruction-memory ack timeout and the datapath word width.
//  Contents    : XLEN                 - datapath / address width (32)
//                RESET_PC_DEFAULT     - PC loaded on reset
//                ACK_TIMEOUT_DEFAULT  - cycles allowed waiting for imem_ack
//                fetch_state_t        - REQ / HOLD / ERR
//                is_word_aligned()    - true when an address is 4-byte aligned
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam int ACK_TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_ERR  = 2'd2
   } fetch_state_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch
//  Description : Instruction-fetch stage sitting between the next-PC logic
//                and decode. Issues a read for the current PC, captures the
//                returned word, holds it until decode takes it, then loads
//                the next PC and requests again. A missing ack or a
//                misaligned next PC raises a sticky error and parks the
//                block until reset.
//  Parameters  : RESET_PC     - PC value loaded on reset
//                ACK_TIMEOUT  - cycles spent waiting for imem_ack before error
//  Ports       : clk          in   clock, rising edge
//                reset        in   asynchronous active-high reset
//                next_pc      in   [31:0] next PC, sampled on hand-off only
//                stall        in   hazard stall, blocks hand-off
//                decode_ready in   decode accepts the held instruction
//                imem_ack     in   instruction memory returns data
//                imem_rdata   in   [31:0] instruction word (valid with ack)
//                imem_req     out  registered read request
//                imem_addr    out  [31:0] read address (equals pc)
//                pc           out  [31:0] current PC
//                instruction  out  [31:0] registered instruction word
//                instr_valid  out  instruction not yet handed off
//                fetch_err    out  sticky error flag
//                retired      out  [31:0] completed hand-off count
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int              ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   next_pc,
   input  logic              stall,
   input  logic              decode_ready,
   input  logic              imem_ack,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   instruction,
   output logic              instr_valid,
   output logic              fetch_err,
   output logic [XLEN-1:0]   retired
);

   localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   fetch_state_t      state_q,    state_d;
   logic [XLEN-1:0]   pc_q,       pc_d;
   logic [XLEN-1:0]   instr_q,    instr_d;
   logic              valid_q,    valid_d;
   logic              req_q,      req_d;
   logic              err_q,      err_d;
   logic [XLEN-1:0]   retired_q,  retired_d;
   logic [WAIT_W-1:0] wait_q,     wait_d;

   logic              handoff;

   assign handoff = decode_ready & ~stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      req_d     = req_q;
      err_d     = err_q;
      retired_d = retired_q;
      wait_d    = wait_q;

      case (state_q)
         ST_REQ: begin
            // The request is registered, so the first cycle after reset
            // drives imem_req=0 and the flop rises on the following edge.
            req_d = 1'b1;
            if (imem_ack) begin
               // An ack on the final waiting cycle still wins over the timeout.
               instr_d = imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = ST_HOLD;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         ST_HOLD: begin
            if (handoff) begin
               valid_d = 1'b0;
               if (is_word_aligned(next_pc)) begin
                  pc_d      = next_pc;
                  retired_d = retired_q + 32'd1;
                  req_d     = 1'b1;
                  wait_d    = '0;
                  state_d   = ST_REQ;
               end else begin
                  // Misaligned target: PC and retire count keep their values
                  // so the faulting context is visible after the error.
                  err_d   = 1'b1;
                  req_d   = 1'b0;
                  state_d = ST_ERR;
               end
            end
         end

         ST_ERR: begin
            // Terminal: everything holds until reset.
         end

         default: begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            valid_d = 1'b0;
            state_d = ST_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_REQ;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         req_q     <= 1'b0;
         err_q     <= 1'b0;
         retired_q <= '0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         req_q     <= req_d;
         err_q     <= err_d;
         retired_q <= retired_d;
         wait_q    <= wait_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   assign retired     = retired_q;

endmodule : pc_fetch
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch
//  Description : Directed self-checking bench for pc_fetch. A table of
//                per-cycle {inputs, expected outputs} records drives the main
//                fetch / hold / hand-off / timeout flow; short hand-written
//                sequences cover misaligned hand-off, asynchronous reset
//                mid-wait and retired-count wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] next_pc = '0;
   logic        stall = 1'b0;
   logic        decode_ready = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        fetch_err;
   logic [31:0] retired;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch #(
      .RESET_PC    (32'h0000_0000),
      .ACK_TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .next_pc      (next_pc),
      .stall        (stall),
      .decode_ready (decode_ready),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .pc           (pc),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .fetch_err    (fetch_err),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        dr;
      logic        ack;
      logic [31:0] rdata;
      logic [31:0] npc;
      logic        e_req;
      logic        e_valid;
      logic        e_err;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_ret;
   } vec_t;

   localparam int NVEC = 29;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic st, input logic dr, input logic ack,
                               input logic [31:0] rd, input logic [31:0] npc,
                               input logic e_req, input logic e_valid,
                               input logic e_err, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [31:0] e_ret);
      vec_t v;
      v.stall = st;    v.dr = dr;         v.ack = ack;
      v.rdata = rd;    v.npc = npc;
      v.e_req = e_req; v.e_valid = e_valid; v.e_err = e_err;
      v.e_pc = e_pc;   v.e_instr = e_instr; v.e_ret = e_ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_req, input logic e_valid,
                          input logic e_err, input logic [31:0] e_pc,
                          input logic [31:0] e_instr, input logic [31:0] e_ret);
      chk({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
      chk({tag, ".fetch_err"},   {31'd0, fetch_err},   {31'd0, e_err});
      chk({tag, ".pc"},          pc,                   e_pc);
      chk({tag, ".imem_addr"},   imem_addr,            e_pc);
      chk({tag, ".instruction"}, instruction,          e_instr);
      chk({tag, ".retired"},     retired,              e_ret);
   endtask

   // Drive one cycle of inputs at the falling edge, check just after the rise.
   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      stall        = v.stall;
      decode_ready = v.dr;
      imem_ack     = v.ack;
      imem_rdata   = v.rdata;
      next_pc      = v.npc;
      @(posedge clk);
      #1;
      chk_all(tag, v.e_req, v.e_valid, v.e_err, v.e_pc, v.e_instr, v.e_ret);
   endtask

   task automatic sync_reset_pulse();
      @(negedge clk);
      reset = 1'b1;
      stall = 1'b0; decode_ready = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; next_pc = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      // ---------------- table --------------------------------------------
      // Rows 0-2: fetch after reset, ack on cycle 3.
      vecs[0]  = mk(0,0,0, 32'h0,         32'h0,   1,0,0, 32'h0,   32'h0,         32'd0);
      vecs[1]  = mk(0,0,0, 32'h0,         32'h0,   1,0,0, 32'h0,   32'h0,         32'd0);
      vecs[2]  = mk(0,0,1, 32'h2002_0005, 32'h0,   0,1,0, 32'h0,   32'h2002_0005, 32'd0);
      // Rows 3-5: stalled while decode is ready, nothing moves.
      vecs[3]  = mk(1,1,0, 32'h0,         32'h4,   0,1,0, 32'h0,   32'h2002_0005, 32'd0);
      vecs[4]  = mk(1,1,0, 32'h0,         32'h4,   0,1,0, 32'h0,   32'h2002_0005, 32'd0);
      vecs[5]  = mk(1,1,0, 32'h0,         32'h4,   0,1,0, 32'h0,   32'h2002_0005, 32'd0);
      // Row 6: stall drops, hand-off to 4.
      vecs[6]  = mk(0,1,0, 32'h0,         32'h4,   1,0,0, 32'h4,   32'h2002_0005, 32'd1);
      // Row 7: immediate ack.
      vecs[7]  = mk(0,0,1, 32'h1111_0013, 32'h0,   0,1,0, 32'h4,   32'h1111_0013, 32'd1);
      // Row 8: ack in HOLD is ignored, decode not ready.
      vecs[8]  = mk(0,0,1, 32'hDEAD_BEEF, 32'h0,   0,1,0, 32'h4,   32'h1111_0013, 32'd1);
      // Row 9: hand-off to 0x100.
      vecs[9]  = mk(0,1,0, 32'h0,         32'h100, 1,0,0, 32'h100, 32'h1111_0013, 32'd2);
      vecs[10] = mk(0,0,1, 32'hAAAA_5555, 32'h0,   0,1,0, 32'h100, 32'hAAAA_5555, 32'd2);
      vecs[11] = mk(0,1,0, 32'h0,         32'h8,   1,0,0, 32'h8,   32'hAAAA_5555, 32'd3);
      // Rows 12-26: fifteen cycles of waiting, still no error.
      for (int i = 12; i <= 26; i++)
         vecs[i] = mk(0,0,0, 32'h0, 32'h0, 1,0,0, 32'h8, 32'hAAAA_5555, 32'd3);
      // Row 27: sixteenth waiting cycle raises the error.
      vecs[27] = mk(0,0,0, 32'h0,         32'h0,   0,0,1, 32'h8,   32'hAAAA_5555, 32'd3);
      // Row 28: late ack and hand-off attempt are ignored in ERR.
      vecs[28] = mk(0,1,1, 32'h1234_5678, 32'hC,   0,0,1, 32'h8,   32'hAAAA_5555, 32'd3);

      // ---------------- reset state --------------------------------------
      #1 reset = 1'b1;
      #1 chk_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++)
         apply($sformatf("v%0d", i), vecs[i]);

      // ---------------- misaligned hand-off ------------------------------
      sync_reset_pulse();
      apply("mis0", mk(0,0,0, 32'h0,         32'h0, 1,0,0, 32'h0, 32'h0,         32'd0));
      apply("mis1", mk(0,0,1, 32'h0000_0013, 32'h0, 0,1,0, 32'h0, 32'h0000_0013, 32'd0));
      apply("mis2", mk(0,1,0, 32'h0,         32'h6, 0,0,1, 32'h0, 32'h0000_0013, 32'd0));
      apply("mis3", mk(0,1,1, 32'hFFFF_0000, 32'h8, 0,0,1, 32'h0, 32'h0000_0013, 32'd0));

      // ---------------- asynchronous reset mid-wait ----------------------
      sync_reset_pulse();
      apply("ar0", mk(0,0,0, 32'h0,         32'h0,  1,0,0, 32'h0,  32'h0,         32'd0));
      apply("ar1", mk(0,0,1, 32'h5555_0001, 32'h0,  0,1,0, 32'h0,  32'h5555_0001, 32'd0));
      apply("ar2", mk(0,1,0, 32'h0,         32'h20, 1,0,0, 32'h20, 32'h5555_0001, 32'd1));
      apply("ar3", mk(0,0,0, 32'h0,         32'h0,  1,0,0, 32'h20, 32'h5555_0001, 32'd1));
      #2 reset = 1'b1;
      #1 chk_all("ar_async", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      imem_ack = 1'b0; decode_ready = 1'b0;
      @(posedge clk);
      #1 chk_all("ar_restart", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);

      // ---------------- retired wrap --------------------------------------
      sync_reset_pulse();
      apply("wr0", mk(0,0,1, 32'h0000_0073, 32'h0, 1'b0,1,0, 32'h0, 32'h0000_0073, 32'd0));
      @(negedge clk);
      dut.retired_q <= 32'hFFFF_FFFF;
      stall = 1'b0; decode_ready = 1'b1; imem_ack = 1'b0; next_pc = 32'h10;
      @(posedge clk);
      #1 chk_all("wrap", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0000_0073, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

   // Absolute guard so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pc_fetch
`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, 16, maximum cycles spent waiting for imem_ack before an error is raised.
REQ-003 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 next_pc  input  32  next-PC value from the next-PC logic, sampled only on an instruction hand-off.
REQ-006 stall  input  1  hazard stall; blocks the hand-off while high.
REQ-007 decode_ready  input  1  decode stage accepts the held instruction.
REQ-008 imem_ack  input  1  instruction memory returns data this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 imem_req  output  1  registered read request to instruction memory.
REQ-011 imem_addr  output  32  read address; always equals pc.
REQ-012 pc  output  32  current PC register; feeds the next-PC logic.
REQ-013 instruction  output  32  registered instruction word for decode and next-PC logic.
REQ-014 instr_valid  output  1  instruction holds a fetched word not yet handed off.
REQ-015 fetch_err  output  1  sticky error flag.
REQ-016 retired  output  32  count of completed hand-offs.

Function
REQ-017 FSM states SHALL be REQ, HOLD and ERR; REQ is the state entered from reset.
REQ-018 In REQ: imem_req=1 and instr_valid=0; on imem_ack=1, instruction<=imem_rdata, instr_valid<=1, imem_req<=0, state<=HOLD.
REQ-019 In REQ: a wait counter SHALL increment each cycle without imem_ack and clear on entry to REQ.
REQ-020 When the wait counter reaches ACK_TIMEOUT-1 without imem_ack: fetch_err<=1, imem_req<=0, state<=ERR.
REQ-021 In HOLD: instruction and pc SHALL stay stable while (decode_ready & ~stall)=0.
REQ-022 Hand-off occurs in HOLD when decode_ready=1 and stall=0 in the same cycle; on hand-off: pc<=next_pc, instr_valid<=0, retired<=retired+1 (32-bit wrap from FFFF_FFFF to 0), imem_req<=1, state<=REQ.
REQ-023 A hand-off with next_pc[1:0]!=0 SHALL NOT load pc or increment retired; instead fetch_err<=1, instr_valid<=0, imem_req<=0, state<=ERR.
REQ-024 ERR is terminal until reset: all outputs hold and imem_ack is ignored.
REQ-025 imem_ack arriving in HOLD or ERR SHALL be ignored.
REQ-026 Fetch latency: an ack on cycle N SHALL give instr_valid=1 on cycle N+1; the next request is issued on the cycle after hand-off.

Reset
REQ-027 Asserting reset at any time, including mid-request, SHALL immediately set pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, fetch_err=0, retired=0, wait counter=0, state=REQ.
REQ-028 imem_req SHALL rise on the first rising clk edge after reset deasserts.

Structure
REQ-029 Shared package holds the state enumeration, RESET_PC default, ACK_TIMEOUT default and the 32-bit word-width constant.
REQ-030 The block is a single module with no sub-modules; pc_fetch is instantiated between the next-PC logic and decode.

Verification
REQ-031 Reset release, then ack with rdata=0x2002_0005 on cycle 3 -> imem_addr=0, instr_valid=1 on cycle 4, instruction=0x2002_0005.
REQ-032 HOLD with decode_ready=1 and stall=1 for 3 cycles, then stall=0 and next_pc=0x0000_0004 -> pc unchanged for 3 cycles, then pc=4, retired=1, imem_req=1.
REQ-033 No ack for 16 cycles in REQ -> fetch_err=1 and imem_req=0 on the 16th cycle; a later ack does not change instruction.
REQ-034 Hand-off with next_pc=0x0000_0006 -> fetch_err=1, pc unchanged, retired unchanged, state ERR.
REQ-035 Reset asserted asynchronously while imem_req=1 mid-wait -> all outputs reset with no clock edge; fetch restarts from RESET_PC.
REQ-036 Preload retired=0xFFFF_FFFF, then one hand-off -> retired=0.
